// File: rtl/aud_i2s_tx_master.sv
// I2S master transmitter: derives BCLK/LRCK from i_clk and shifts out stereo PCM MSB-first.
// Optional macro AUD_TX_REPEAT_EN: an underrun replays the previous frame instead of silence.
module aud_i2s_tx_master #(
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_left,
    input  logic [DATA_W-1:0] i_right,
    output logic              o_ready,
    output logic              o_aud_bclk,
    output logic              o_aud_lrck,
    output logic              o_aud_dat,
    output logic              o_frame_start,
    output logic              o_underrun
);

    localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              buf_full_q, buf_full_d;
    logic [DATA_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [DATA_W-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
    logic              ready_q, ready_d;
    logic              bclk_q, bclk_d, lrck_q, lrck_d, dat_q, dat_d;
    logic              fs_q, fs_d, ur_q, ur_d;
    logic              frame_start, accept, run;

    // Slot position 0 carries the I2S one-bit delay; positions 1..DATA_W carry the sample MSB-first.
    function automatic logic slot_bit(input logic [DATA_W-1:0] l,
                                      input logic [DATA_W-1:0] r,
                                      input logic [BIT_W-1:0]  bc);
        int   pos;
        int   k;
        logic b;
        pos = int'(bc);
        k   = (pos >= SLOT_W) ? (pos - SLOT_W) : pos;
        b   = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (k == DATA_W - i) begin
                b = (pos >= SLOT_W) ? r[i] : l[i];
            end else begin
                b = b;
            end
        end
        return b;
    endfunction

    // Next-state, counters, buffer and output decode.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        buf_full_d  = buf_full_q;
        buf_l_d     = buf_l_q;
        buf_r_d     = buf_r_q;
        tx_l_d      = tx_l_q;
        tx_r_d      = tx_r_q;
        frame_start = 1'b0;
        accept      = i_valid && ready_q;

        case (state_q)
            ST_IDLE: begin
                div_cnt_d = DIV_W'(0);
                bit_cnt_d = BIT_W'(0);
                if (i_en) begin
                    state_d     = ST_RUN;
                    frame_start = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = DIV_W'(0);
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = BIT_W'(0);
                        if (i_en) begin
                            frame_start = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                div_cnt_d = DIV_W'(0);
                bit_cnt_d = BIT_W'(0);
            end
        endcase

        // Buffer is sampled before this cycle's transfer, so a coincident push waits a frame.
        if (frame_start) begin
            if (buf_full_q) begin
                tx_l_d     = buf_l_q;
                tx_r_d     = buf_r_q;
                buf_full_d = 1'b0;
            end else begin
`ifdef AUD_TX_REPEAT_EN
                tx_l_d = tx_l_q;
                tx_r_d = tx_r_q;
`else
                tx_l_d = {DATA_W{1'b0}};
                tx_r_d = {DATA_W{1'b0}};
`endif
            end
        end else begin
            tx_l_d = tx_l_q;
            tx_r_d = tx_r_q;
        end

        if (accept) begin
            buf_full_d = 1'b1;
            buf_l_d    = i_left;
            buf_r_d    = i_right;
        end else begin
            buf_l_d = buf_l_q;
            buf_r_d = buf_r_q;
        end

        run     = (state_d == ST_RUN);
        ready_d = !buf_full_d;
        bclk_d  = run && (int'(div_cnt_d) >= BCLK_DIV / 2);
        lrck_d  = run && (int'(bit_cnt_d) >= SLOT_W);
        dat_d   = run && slot_bit(tx_l_d, tx_r_d, bit_cnt_d);
        fs_d    = frame_start;
        ur_d    = frame_start && !buf_full_q;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= DIV_W'(0);
            bit_cnt_q  <= BIT_W'(0);
            buf_full_q <= 1'b0;
            buf_l_q    <= {DATA_W{1'b0}};
            buf_r_q    <= {DATA_W{1'b0}};
            tx_l_q     <= {DATA_W{1'b0}};
            tx_r_q     <= {DATA_W{1'b0}};
            ready_q    <= 1'b1;
            bclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            dat_q      <= 1'b0;
            fs_q       <= 1'b0;
            ur_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            buf_full_q <= buf_full_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            tx_l_q     <= tx_l_d;
            tx_r_q     <= tx_r_d;
            ready_q    <= ready_d;
            bclk_q     <= bclk_d;
            lrck_q     <= lrck_d;
            dat_q      <= dat_d;
            fs_q       <= fs_d;
            ur_q       <= ur_d;
        end
    end

    assign o_ready       = ready_q;
    assign o_aud_bclk    = bclk_q;
    assign o_aud_lrck    = lrck_q;
    assign o_aud_dat     = dat_q;
    assign o_frame_start = fs_q;
    assign o_underrun    = ur_q;

endmodule

// File: tb/tb_aud_i2s_tx_master.sv
// Self-checking bench for aud_i2s_tx_master: frame-level reference model feeding a scoreboard
// of expected frames, plus per-cycle checks of the clock, handshake and event outputs.
`timescale 1ns/1ps
module tb_aud_i2s_tx_master;

    localparam int DATA_W   = 16;
    localparam int SLOT_W   = 32;
    localparam int BCLK_DIV = 4;
    localparam int FRAME    = 2 * SLOT_W * BCLK_DIV;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] left  = 16'h0000;
    logic [15:0] right = 16'h0000;
    logic        o_ready, o_bclk, o_lrck, o_dat, o_fs, o_ur;

    always #5 clk = ~clk;

    aud_i2s_tx_master #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_valid      (valid),
        .i_left       (left),
        .i_right      (right),
        .o_ready      (o_ready),
        .o_aud_bclk   (o_bclk),
        .o_aud_lrck   (o_lrck),
        .o_aud_dat    (o_dat),
        .o_frame_start(o_fs),
        .o_underrun   (o_ur)
    );

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } frame_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    frame_t sb[$];
    vec_t   vecs[5];

    int errors = 0;
    int checks = 0;

    // reference model state
    logic        m_run = 1'b0;
    int          m_ph  = 0;
    logic        m_full = 1'b0;
    logic        m_fs = 1'b0, m_ur = 1'b0, m_acc = 1'b0;
    logic [15:0] m_bl = 16'h0000, m_br = 16'h0000;
    logic [15:0] m_last_l = 16'h0000, m_last_r = 16'h0000;
    logic [15:0] exp_l = 16'h0000, exp_r = 16'h0000;
    logic [63:0] cap = 64'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        frame_t f;
        logic   fs;
        if (!rst_n) begin
            m_run = 1'b0; m_ph = 0; m_full = 1'b0;
            m_fs = 1'b0; m_ur = 1'b0; m_acc = 1'b0;
            m_last_l = 16'h0000; m_last_r = 16'h0000;
            sb.delete();
        end else begin
            fs    = 1'b0;
            m_acc = valid && !m_full;
            if (!m_run) begin
                if (en) begin m_run = 1'b1; m_ph = 0; fs = 1'b1; end
            end else if (m_ph == FRAME - 1) begin
                m_ph = 0;
                if (en) fs = 1'b1;
                else    m_run = 1'b0;
            end else begin
                m_ph++;
            end
            m_ur = fs && !m_full;
            if (fs) begin
                if (m_full) begin
                    f.l = m_bl; f.r = m_br; m_full = 1'b0;
                end else begin
`ifdef AUD_TX_REPEAT_EN
                    f.l = m_last_l; f.r = m_last_r;
`else
                    f.l = 16'h0000; f.r = 16'h0000;
`endif
                end
                m_last_l = f.l; m_last_r = f.r;
                sb.push_back(f);
            end
            m_fs = fs;
            if (m_acc) begin m_full = 1'b1; m_bl = exp_l; m_br = exp_r; end
        end
    endtask

    task automatic check_outputs();
        frame_t      f;
        logic [15:0] wl, wr;
        int          pad;
        chk("ready", 32'(o_ready), 32'(!m_full));
        chk("bclk", 32'(o_bclk), 32'(m_run && ((m_ph % BCLK_DIV) >= BCLK_DIV / 2)));
        chk("lrck", 32'(o_lrck), 32'(m_run && ((m_ph / BCLK_DIV) >= SLOT_W)));
        chk("frame_start", 32'(o_fs), 32'(m_fs));
        chk("underrun", 32'(o_ur), 32'(m_ur));
        if (!m_run) chk("dat_idle", 32'(o_dat), 32'd0);
        // receiver samples DAT on each rising BCLK
        if (m_run && (m_ph % BCLK_DIV) == BCLK_DIV / 2) begin
            cap[m_ph / BCLK_DIV] = o_dat;
            if (m_ph / BCLK_DIV == 2 * SLOT_W - 1) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    f = sb.pop_front();
                    for (int i = 0; i < DATA_W; i++) begin
                        wl[DATA_W-1-i] = cap[1 + i];
                        wr[DATA_W-1-i] = cap[SLOT_W + 1 + i];
                    end
                    pad = 0;
                    for (int k = 0; k < 2 * SLOT_W; k++) begin
                        if (((k % SLOT_W) == 0 || (k % SLOT_W) > DATA_W) && cap[k]) pad++;
                    end
                    chk("left_word", 32'(wl), 32'(f.l));
                    chk("right_word", 32'(wr), 32'(f.r));
                    chk("pad_bits", 32'(pad), 32'd0);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_ph(input int target);
        for (int n = 0; n < 2 * FRAME; n++) begin
            step();
            if (m_run && m_ph == target) return;
        end
        chk("wait_ph_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 2 * FRAME; n++) begin
            step();
            if (!m_run) return;
        end
        chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        valid = 1'b1; left = l; right = r; exp_l = l; exp_r = r;
        for (int n = 0; n < 2 * FRAME; n++) begin
            step();
            if (m_acc) begin valid = 1'b0; return; end
        end
        valid = 1'b0;
        chk("push_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        vecs[0] = '{l: 16'h0001, r: 16'h8000, exp_l: 16'h0001, exp_r: 16'h8000};
        vecs[1] = '{l: 16'hFFFF, r: 16'h0000, exp_l: 16'hFFFF, exp_r: 16'h0000};
        vecs[2] = '{l: 16'h8000, r: 16'h7FFF, exp_l: 16'h8000, exp_r: 16'h7FFF};
        vecs[3] = '{l: 16'h1234, r: 16'hFEDC, exp_l: 16'h1234, exp_r: 16'hFEDC};
        vecs[4] = '{l: 16'h0F0F, r: 16'hF0F0, exp_l: 16'h0F0F, exp_r: 16'hF0F0};

        // reset state
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // basic frame, then an underrun frame
        push(16'hA5C3, 16'h0001);
        en = 1'b1;
        step();
        wait_ph(FRAME - 1);
        step();
        wait_ph(FRAME - 1);

        // push coincident with an underrun frame start lands in the next frame
        push(16'hB00F, 16'h7FFF);
        wait_ph(FRAME - 1);
        step();

        // back-to-back frames with valid held high
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1; left = vecs[i].l; right = vecs[i].r;
            exp_l = vecs[i].exp_l; exp_r = vecs[i].exp_r;
            for (int n = 0; n < 2 * FRAME; n++) begin
                step();
                if (m_acc) break;
            end
        end
        valid = 1'b0;
        wait_ph(FRAME - 1);
        step();
        wait_ph(FRAME - 1);
        step();

        // enable dropped mid-frame: frame completes, then idle, then restart
        wait_ph(10 * BCLK_DIV);
        en = 1'b0;
        wait_idle();
        repeat (20) step();
        en = 1'b1;
        step();

        // reset mid-frame discards the pending buffered frame
        push(16'h1234, 16'h5678);
        wait_ph(40 * BCLK_DIV);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        wait_ph(FRAME - 1);
        step();

        en = 1'b0;
        wait_idle();
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aud_i2s_tx_master.md
Name: aud_i2s_tx_master

Overview:
- I2S master transmitter: generates BCLK and LRCK from i_clk and serializes stereo PCM frames on a data line, MSB first, in standard I2S format.
- Counterpart of the audio recorder's I2S receive path.
- Drives the codec-side bus when the FPGA is clock master, and serves as a codec-ADC emulator for recorder loopback benches.
- Samples arrive as one stereo frame per valid/ready transfer, through a one-entry holding buffer.

Parameters:
DATA_W, 16, bits per channel sample; must satisfy 1 <= DATA_W <= SLOT_W-1.
SLOT_W, 32, BCLK periods per channel slot; one frame is 2*SLOT_W BCLK periods.
BCLK_DIV, 4, i_clk cycles per BCLK period; even, >= 2.

Ports:
i_clk  in  1  system clock (12 MHz domain)
i_rst_n  in  1  synchronous active-low reset
i_en  in  1  run enable
i_valid  in  1  frame available on i_left/i_right
i_left  in  DATA_W  left sample, two's complement
i_right  in  DATA_W  right sample, two's complement
o_ready  out  1  holding buffer empty; accepts a frame
o_aud_bclk  out  1  bit clock
o_aud_lrck  out  1  word select; 0 = left, 1 = right
o_aud_dat  out  1  serial data
o_frame_start  out  1  1-cycle pulse when a frame begins transmission
o_underrun  out  1  1-cycle pulse when a frame begins with the buffer empty

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - Outputs: o_aud_bclk, o_aud_lrck, o_aud_dat, o_frame_start, o_underrun = 0; o_ready = 1.
  - Internal: buffer emptied, counters cleared, state IDLE.
  - Reset mid-frame aborts the frame immediately; there is no drain.
- Handshake:
  - A transfer occurs on a cycle with i_valid && o_ready; the frame is written to the buffer and o_ready = 0 from the next cycle.
  - o_ready returns to 1 in the cycle after the buffer is unloaded.
  - Transfers are accepted in both IDLE and RUN.
- Counters:
  - div_cnt runs 0..BCLK_DIV-1.
  - o_aud_bclk = 0 while div_cnt < BCLK_DIV/2, else 1.
  - A BCLK falling edge occurs when div_cnt wraps to 0. bit_cnt (0..2*SLOT_W-1) advances on each falling edge, wrapping to 0.
  - o_aud_lrck = (bit_cnt >= SLOT_W).
- Data placement within slot position k = bit_cnt mod SLOT_W:
  - k = 0: 0 (I2S one-bit delay).
  - k = 1..DATA_W: sample[DATA_W-k].
  - k > DATA_W: 0.
  - All outputs are registered and change only on falling edges. A receiver samples on rising BCLK.
- Frame start event: the cycle in which bit_cnt becomes 0.
  - If the buffer is full: load both samples into the shift registers, empty the buffer, pulse o_frame_start.
  - If the buffer is empty: load zeros, pulse both o_frame_start and o_underrun.
  - If a transfer into an empty buffer coincides with a frame start, the frame is an underrun and the new data waits for the next frame.
- State machine:
  - IDLE: BCLK/LRCK/DAT held 0, counters at 0.
    - IDLE -> RUN when i_en = 1. div_cnt = 0 and bit_cnt = 0 on the first RUN cycle, which is a frame start event.
  - RUN: counters run as above.
    - RUN -> IDLE when i_en = 0 is sampled at the end of a frame, i.e. when bit_cnt would wrap to 0.
    - Deasserting i_en mid-frame completes the current frame; the following frame is not started and no frame start event occurs.

Optional Feature:
- Macro AUD_TX_REPEAT_EN.
- Defined: on underrun the previously transmitted left/right samples are reloaded instead of zeros, which holds the last output level. o_underrun still pulses. After reset, the last frame is zero.
- Undefined: underrun loads zeros.

Test Plan:
All scenarios use defaults (DATA_W=16, SLOT_W=32, BCLK_DIV=4): one frame = 256 i_clk cycles.
1. Push L=16'hA5C3, R=16'h0001 with i_en=1 -> o_frame_start pulse; sample o_aud_dat on rising BCLK:
   - left slot bit positions 1..16 read 0xA5C3, position 0 and 17..31 read 0;
   - LRCK rises at slot 32; right slot reads 0x0001;
   - BCLK period 4 cycles, 50% duty.
2. No push after the first frame -> o_underrun pulses at the second frame start and the second frame is all zeros; with AUD_TX_REPEAT_EN the second frame repeats 0xA5C3/0x0001.
3. i_valid held high with incrementing data -> o_ready drops the cycle after each accept and reasserts the cycle after each frame start; exactly one frame per 256 cycles, no frame skipped or duplicated.
4. i_en dropped at bit_cnt=10 -> frame completes through bit_cnt=63, then BCLK/LRCK/DAT stay 0; re-raising i_en starts a new frame with bit_cnt=0.
5. i_rst_n=0 at bit_cnt=40 -> all outputs 0 and o_ready=1 on the next cycle; the pending buffered frame is discarded.
6. Push coincident with an underrun frame start -> o_underrun pulses and the pushed data appears in the following frame.
